// File: rtl/r22sdf_pkg.sv
// Shared definitions for the radix-2^2 SDF FFT stages.
package r22sdf_pkg;

    localparam int unsigned BF2I  = 0;
    localparam int unsigned BF2II = 1;

    // Ceiling log2 for parameter elaboration; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/r22sdf_delay_buf.sv
// Circular L-entry feedback buffer: one shared read/write pointer, advanced per enabled cycle.
module r22sdf_delay_buf
    import r22sdf_pkg::*;
#(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             en,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             last_c
);

    generate
        if (DEPTH == 1) begin : g_single
            logic [WIDTH-1:0] mem_q;

            always_ff @(posedge i_clk or negedge i_rstn) begin
                if (!i_rstn) begin
                    mem_q <= '0;
                end else if (en) begin
                    mem_q <= wdata;
                end
            end

            assign rdata  = mem_q;
            assign last_c = en;
        end else begin : g_ring
            localparam int unsigned PW = clog2(DEPTH);

            logic [PW-1:0]    ptr;
            logic [WIDTH-1:0] mem [DEPTH];
            logic             at_end;

            assign at_end = (ptr == PW'(DEPTH - 1));

            always_ff @(posedge i_clk or negedge i_rstn) begin
                if (!i_rstn) begin
                    ptr <= '0;
                    mem <= '{default: '0};
                end else if (en) begin
                    mem[ptr] <= wdata;
                    ptr      <= at_end ? '0 : ptr + PW'(1);
                end
            end

            // Read is combinational so the butterfly sees the entry being overwritten.
            assign rdata  = mem[ptr];
            assign last_c = en && at_end;
        end
    endgenerate

endmodule

// File: rtl/r22sdf_bf_stage.sv
// Radix-2^2 SDF butterfly stage (BF2I, or BF2II with -j on the last quarter period).
module r22sdf_bf_stage
    import r22sdf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DELAY_LEN  = 32,
    parameter int unsigned BF_TYPE    = BF2I
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_valid,
    input  logic                  i_sync,
    input  logic [DATA_WIDTH-1:0] i_real,
    input  logic [DATA_WIDTH-1:0] i_imag,
    output logic                  o_valid,
    output logic [DATA_WIDTH:0]   o_real,
    output logic [DATA_WIDTH:0]   o_imag
);

    localparam int unsigned OW       = DATA_WIDTH + 1;
    localparam int unsigned LOG2L    = clog2(DELAY_LEN);
    localparam bit          IS_BF2II = (BF_TYPE == BF2II);
    localparam int unsigned CW       = LOG2L + (IS_BF2II ? 2 : 1);

    typedef struct packed {
        logic signed [OW-1:0] re;
        logic signed [OW-1:0] im;
    } cplx_t;

    logic [CW-1:0] cnt;
    logic [CW-1:0] idx_c;
    logic          s_c;
    logic          t_c;
    logic          primed;
    logic          wrap_c;
    cplx_t         x_c;
    cplx_t         fb_c;
    cplx_t         sum_c;
    cplx_t         dif_c;
    cplx_t         out_c;
    cplx_t         wr_c;

    r22sdf_delay_buf #(
        .WIDTH (2 * OW),
        .DEPTH (DELAY_LEN)
    ) u_delay (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .en     (i_valid),
        .wdata  (wr_c),
        .rdata  (fb_c),
        .last_c (wrap_c)
    );

    // Phase decode, input conditioning and butterfly arithmetic.
    always_comb begin
        idx_c = cnt;
        if (i_valid && i_sync) begin
            idx_c = '0;
        end
        s_c = idx_c[LOG2L];
        t_c = IS_BF2II ? idx_c[CW-1] : 1'b0;

        x_c.re = OW'($signed(i_real));
        x_c.im = OW'($signed(i_imag));
        // -j rotation: (re, im) -> (im, -re); negation is exact at OW bits.
        if (IS_BF2II && s_c && t_c) begin
            x_c.re = OW'($signed(i_imag));
            x_c.im = -OW'($signed(i_real));
        end

        sum_c.re = fb_c.re + x_c.re;
        sum_c.im = fb_c.im + x_c.im;
        dif_c.re = fb_c.re - x_c.re;
        dif_c.im = fb_c.im - x_c.im;

        out_c = fb_c;
        wr_c  = x_c;
        if (s_c) begin
            out_c = sum_c;
            wr_c  = dif_c;
        end
    end

    // Sample counter, priming flag and registered outputs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt     <= '0;
            primed  <= 1'b0;
            o_valid <= 1'b0;
            o_real  <= '0;
            o_imag  <= '0;
        end else begin
            o_valid <= i_valid && primed;
            if (i_valid) begin
                cnt <= idx_c + CW'(1);
                if (wrap_c) begin
                    primed <= 1'b1;
                end
            end
            if (i_valid && primed) begin
                o_real <= out_c.re;
                o_imag <= out_c.im;
            end
        end
    end

endmodule

// File: tb/tb_r22sdf_bf_stage.sv
// Bench for r22sdf_bf_stage: BF2I (L=4) and BF2II (L=1) instances against a queue-style model.
module tb_r22sdf_bf_stage;

    localparam int unsigned DW = 16;
    localparam int unsigned OW = 17;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic          v0, sy0, v1, sy1;
    logic [DW-1:0] r0, i0, r1, i1;
    logic          ov0, ov1;
    logic [OW-1:0] or0, oi0, or1, oi1;

    r22sdf_bf_stage #(.DATA_WIDTH(16), .DELAY_LEN(4), .BF_TYPE(0)) dut0 (
        .i_clk(clk), .i_rstn(rstn), .i_valid(v0), .i_sync(sy0),
        .i_real(r0), .i_imag(i0), .o_valid(ov0), .o_real(or0), .o_imag(oi0));

    r22sdf_bf_stage #(.DATA_WIDTH(16), .DELAY_LEN(1), .BF_TYPE(1)) dut1 (
        .i_clk(clk), .i_rstn(rstn), .i_valid(v1), .i_sync(sy1),
        .i_real(r1), .i_imag(i1), .o_valid(ov1), .o_real(or1), .o_imag(oi1));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at %0t",
                     name, $signed(act), act, $signed(exp), exp, $time);
        end
    endtask

    // Reference model: delay line as a shift list (oldest at index L-1), integer arithmetic.
    int   m_cnt  [2];
    int   m_seen [2];
    int   m_dre  [2][4];
    int   m_dim  [2][4];
    logic m_ov   [2];
    int   m_re   [2];
    int   m_im   [2];

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            m_cnt[n] = 0; m_seen[n] = 0; m_ov[n] = 1'b0; m_re[n] = 0; m_im[n] = 0;
            for (int j = 0; j < 4; j++) begin
                m_dre[n][j] = 0; m_dim[n][j] = 0;
            end
        end
    endtask

    task automatic model_step(input int n, input int len, input bit bf2, input bit v,
                              input bit sy, input int re, input int im);
        int k, xr, xi, fr, fi, outr, outi;
        bit s, t;
        if (!v) begin
            m_ov[n] = 1'b0;
            return;
        end
        k = sy ? 0 : m_cnt[n];
        s = ((k / len) % 2) == 1;
        t = bf2 && (((k / (2 * len)) % 2) == 1);
        xr = re; xi = im;
        if (s && t) begin
            xr = im; xi = -re;
        end
        fr = m_dre[n][len-1];
        fi = m_dim[n][len-1];
        for (int j = len - 1; j > 0; j--) begin
            m_dre[n][j] = m_dre[n][j-1];
            m_dim[n][j] = m_dim[n][j-1];
        end
        if (s) begin
            outr = fr + xr; outi = fi + xi;
            m_dre[n][0] = fr - xr; m_dim[n][0] = fi - xi;
        end else begin
            outr = fr; outi = fi;
            m_dre[n][0] = xr; m_dim[n][0] = xi;
        end
        m_ov[n] = (m_seen[n] >= len);
        if (m_ov[n]) begin
            m_re[n] = outr; m_im[n] = outi;
        end
        if (m_seen[n] < len) m_seen[n]++;
        m_cnt[n] = (k + 1) % (bf2 ? 4 * len : 2 * len);
    endtask

    // One clock: advance the model with the driven inputs, then compare both DUTs.
    task automatic tick();
        model_step(0, 4, 1'b0, v0, sy0, $signed(r0), $signed(i0));
        model_step(1, 1, 1'b1, v1, sy1, $signed(r1), $signed(i1));
        @(posedge clk);
        #1;
        chk("mdl_ov0", OW'(ov0), OW'(m_ov[0]));
        chk("mdl_re0", or0, OW'(m_re[0]));
        chk("mdl_im0", oi0, OW'(m_im[0]));
        chk("mdl_ov1", OW'(ov1), OW'(m_ov[1]));
        chk("mdl_re1", or1, OW'(m_re[1]));
        chk("mdl_im1", oi1, OW'(m_im[1]));
    endtask

    task automatic idle();
        v0 = 1'b0; sy0 = 1'b0; r0 = '0; i0 = '0;
        v1 = 1'b0; sy1 = 1'b0; r1 = '0; i1 = '0;
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        idle();
        rstn = 1'b0;
        #1;
        chk("rst_ov0", OW'(ov0), '0);
        chk("rst_re0", or0, '0);
        chk("rst_im0", oi0, '0);
        chk("rst_ov1", OW'(ov1), '0);
        chk("rst_re1", or1, '0);
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic feed0(input int re, input bit sy);
        v0 = 1'b1; sy0 = sy; r0 = DW'(re); i0 = '0;
        tick();
        v0 = 1'b0; sy0 = 1'b0;
    endtask

    typedef struct {
        logic v;
        logic sy;
        int   re;
        logic ov;
        int   ore;
    } vec_t;

    vec_t tbl[16];
    int   t1_exp[16] = '{0, 0, 0, 0, 6, 8, 10, 12, -4, -4, -4, -4, 22, 24, 26, 28};
    int   t3_re[4]   = '{3, 3, -1, 3};
    int   t3_im[4]   = '{4, 0, 0, -4};

    initial begin
        int last;
        idle();
        model_reset();
        rstn = 1'b1;
        #2;
        for (int i = 0; i < 16; i++) begin
            tbl[i].v   = 1'b1;
            tbl[i].sy  = (i == 0);
            tbl[i].re  = i + 1;
            tbl[i].ov  = (i >= 4);
            tbl[i].ore = t1_exp[i];
        end

        // Basic BF2I frame from the table.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            v0 = tbl[i].v; sy0 = tbl[i].sy; r0 = DW'(tbl[i].re); i0 = '0;
            tick();
            chk("t1_ov", OW'(ov0), OW'(tbl[i].ov));
            chk("t1_re", or0, OW'(tbl[i].ore));
        end
        idle();

        // Extremes: sums reach the full grown range without wrapping.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            feed0(-32768, i == 0);
            if (i >= 4 && i < 8) chk("t2_min_sum", or0, 17'h10000);
            if (i >= 8)          chk("t2_min_dif", or0, 17'h00000);
        end
        do_reset();
        for (int i = 0; i < 12; i++) begin
            feed0(32767, i == 0);
            if (i >= 4 && i < 8) chk("t2_max_sum", or0, 17'h0FFFE);
            if (i >= 8)          chk("t2_max_dif", or0, 17'h00000);
        end

        // BF2II, L=1: -j on the last quarter.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            v1 = 1'b1; sy1 = (i == 0); r1 = DW'((i % 4) + 1); i1 = '0;
            tick();
            if (i >= 4) begin
                chk("t3_ov", OW'(ov1), OW'(1));
                chk("t3_re", or1, OW'(t3_re[i % 4]));
                chk("t3_im", oi1, OW'(t3_im[i % 4]));
            end
        end
        idle();

        // Valid gaps: same results, o_valid low and outputs held in the gaps.
        do_reset();
        last = 0;
        for (int i = 0; i < 16; i++) begin
            v0 = 1'b0; sy0 = 1'b1; r0 = DW'($urandom); i0 = DW'($urandom);
            tick();
            chk("t4_gap_ov", OW'(ov0), '0);
            chk("t4_gap_re", or0, OW'(last));
            v0 = tbl[i].v; sy0 = tbl[i].sy; r0 = DW'(tbl[i].re); i0 = '0;
            tick();
            chk("t4_ov", OW'(ov0), OW'(tbl[i].ov));
            chk("t4_re", or0, OW'(tbl[i].ore));
            last = tbl[i].ore;
        end
        idle();

        // Resync mid-stream: sample 11 restarts at index 0, no re-priming.
        do_reset();
        for (int i = 1; i <= 14; i++) begin
            feed0(i, (i == 1) || (i == 11));
            if (i == 11) chk("t5_ov", OW'(ov0), OW'(1));
            if (i == 13) chk("t5_re13", or0, OW'(9));
            if (i == 14) chk("t5_re14", or0, OW'(10));
        end

        // Reset mid-frame, then re-prime over L samples.
        do_reset();
        for (int i = 1; i <= 6; i++) feed0(i, i == 1);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            feed0(7 + i, i == 0);
            chk("t6_ov", OW'(ov0), OW'(i == 4));
        end

        // Random streams on both instances.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            v0 = ($urandom_range(0, 99) < 70); sy0 = ($urandom_range(0, 99) < 3);
            r0 = DW'($urandom); i0 = DW'($urandom);
            v1 = ($urandom_range(0, 99) < 70); sy1 = ($urandom_range(0, 99) < 3);
            r1 = DW'($urandom); i1 = DW'($urandom);
            tick();
        end
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
